// File: rtl/watch_display.sv
// Time display back end: binary H/M/S -> BCD by iterative double-dabble, then active-low 7-seg with blink masking.
// Optional build macro WATCH_DISP_LZB_EN blanks a leading zero on the hour-tens digit.
module watch_display #(
    parameter logic [6:0] BLANK = 7'h7F,
    parameter int         NBITS = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] segundos,
    input  logic [5:0] minutos,
    input  logic [4:0] horas,
    input  logic       blink,
    input  logic [1:0] mode,
    output logic [6:0] HEX5,
    output logic [6:0] HEX4,
    output logic [6:0] HEX3,
    output logic [6:0] HEX2,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0,
    output logic       busy
);
    localparam int CW = $clog2(NBITS);
    localparam int SW = NBITS + 8;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t               r_state;
    logic [16:0]          r_snap;
    logic [CW-1:0]        r_cnt;
    logic                 r_valid;
    logic                 r_busy;
    logic [2:0][SW-1:0]   r_scr;
    logic [5:0][3:0]      r_dig;

    logic [16:0]          w_in;
    logic [2:0][NBITS-1:0] w_field;
    logic [2:0][SW-1:0]   w_shift;
    logic [5:0][6:0]      w_seg;
    logic [5:0][6:0]      w_hex;
    logic [2:0]           w_mask;
    logic                 w_lzb;

    assign w_in       = {horas, minutos, segundos};
    assign w_field[0] = NBITS'(segundos);
    assign w_field[1] = NBITS'(minutos);
    assign w_field[2] = NBITS'(horas);

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = BLANK;
        endcase
    endfunction

    // One double-dabble step per field: add-3 on nibbles >= 5, then shift left.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dd
            logic [3:0]    w_lo;
            logic [3:0]    w_hi;
            logic [SW-1:0] w_adj;
            assign w_lo  = r_scr[gi][NBITS+3:NBITS];
            assign w_hi  = r_scr[gi][NBITS+7:NBITS+4];
            assign w_adj = {(w_hi >= 4'd5) ? w_hi + 4'd3 : w_hi,
                            (w_lo >= 4'd5) ? w_lo + 4'd3 : w_lo,
                            r_scr[gi][NBITS-1:0]};
            assign w_shift[gi] = w_adj << 1;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_snap  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_scr   <= '0;
            r_dig   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_valid || (w_in != r_snap)) begin
                        r_snap <= w_in;
                        for (int i = 0; i < 3; i++) begin
                            r_scr[i] <= {8'd0, w_field[i]};
                        end
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_scr <= w_shift;
                    if (r_cnt == CW'(NBITS - 1)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    for (int i = 0; i < 3; i++) begin
                        r_dig[2*i]   <= r_scr[i][NBITS+3:NBITS];
                        r_dig[2*i+1] <= r_scr[i][NBITS+7:NBITS+4];
                    end
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef WATCH_DISP_LZB_EN
    assign w_lzb = (r_dig[5] == 4'd0);
`else
    assign w_lzb = 1'b0;
`endif

    // Pair index: 2 = hours, 1 = minutes, 0 = seconds.
    assign w_mask[2] = !blink && (mode == 2'b01);
    assign w_mask[1] = !blink && (mode == 2'b10);
    assign w_mask[0] = !blink && (mode == 2'b11);

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_seg
            assign w_seg[gi] = seg7(r_dig[gi]);
            assign w_hex[gi] = (!r_valid || w_mask[gi/2] || ((gi == 5) && w_lzb)) ? BLANK : w_seg[gi];
        end
    endgenerate

    assign HEX0 = w_hex[0];
    assign HEX1 = w_hex[1];
    assign HEX2 = w_hex[2];
    assign HEX3 = w_hex[3];
    assign HEX4 = w_hex[4];
    assign HEX5 = w_hex[5];
    assign busy = r_busy;

endmodule

// File: tb/tb_watch_display.sv
// Bench for watch_display: vector table with a scoreboard queue, plus hand sequences for
// reset release, mid-conversion input change and mid-conversion reset.
module tb_watch_display;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] segundos = '0;
    logic [5:0] minutos = '0;
    logic [4:0] horas = '0;
    logic       blink = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [6:0] HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;
    logic       busy;

    watch_display dut (
        .clk(clk), .rst(rst),
        .segundos(segundos), .minutos(minutos), .horas(horas),
        .blink(blink), .mode(mode),
        .HEX5(HEX5), .HEX4(HEX4), .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0),
        .busy(busy)
    );

    always #10 clk = ~clk;

`ifdef WATCH_DISP_LZB_EN
    localparam logic [6:0] H0 = 7'h7F;
`else
    localparam logic [6:0] H0 = 7'h40;
`endif
    localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

    typedef struct {
        logic [4:0]  h;
        logic [5:0]  m;
        logic [5:0]  s;
        logic [1:0]  md;
        logic        bl;
        logic        conv;
        logic [41:0] exp;
    } vec_t;

    vec_t        vecs[14];
    logic [41:0] sb_q[$];
    int          total = 0;
    int          bad = 0;
    logic [41:0] hex_all;

    assign hex_all = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    function automatic vec_t mk(input int h, input int m, input int s, input int md, input int bl,
                                input int cv, input logic [6:0] e5, input logic [6:0] e4,
                                input logic [6:0] e3, input logic [6:0] e2, input logic [6:0] e1,
                                input logic [6:0] e0);
        vec_t v;
        v.h    = 5'(h);
        v.m    = 6'(m);
        v.s    = 6'(s);
        v.md   = 2'(md);
        v.bl   = 1'(bl);
        v.conv = 1'(cv);
        v.exp  = {e5, e4, e3, e2, e1, e0};
        return v;
    endfunction

    task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic drive(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                         input logic [1:0] md, input logic bl);
        @(posedge clk);
        #1;
        horas = h; minutos = m; segundos = s; mode = md; blink = bl;
    endtask

    // Waits for busy to rise and fall; edges counts posedges from the call.
    task automatic wait_done(output int edges, output bit ok);
        bit seen;
        seen  = 1'b0;
        ok    = 1'b0;
        edges = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) seen = 1'b1;
            else if (seen) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pop_check(input string name);
        logic [41:0] e;
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 42'd0, 42'd1);
        end else begin
            e = sb_q.pop_front();
            check(name, hex_all, e);
        end
    endtask

    initial begin
        int  edges, e2, bcnt, extra;
        bit  ok;

        vecs[0]  = mk(23, 59, 59, 0, 1, 1, 7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10);
        vecs[1]  = mk(12, 34, 56, 0, 1, 1, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02);
        vecs[2]  = mk(12, 34, 56, 2, 0, 0, 7'h79, 7'h24, 7'h7F, 7'h7F, 7'h12, 7'h02);
        vecs[3]  = mk(12, 34, 56, 2, 1, 0, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02);
        vecs[4]  = mk(12, 34, 56, 1, 0, 0, 7'h7F, 7'h7F, 7'h30, 7'h19, 7'h12, 7'h02);
        vecs[5]  = mk(12, 34, 56, 3, 0, 0, 7'h79, 7'h24, 7'h30, 7'h19, 7'h7F, 7'h7F);
        vecs[6]  = mk(12, 34, 56, 0, 0, 0, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02);
        vecs[7]  = mk( 5,  0,  0, 0, 1, 1, H0,    7'h12, 7'h40, 7'h40, 7'h40, 7'h40);
        vecs[8]  = mk( 5,  0,  0, 1, 0, 0, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40);
        vecs[9]  = mk( 5,  0,  0, 1, 1, 0, H0,    7'h12, 7'h40, 7'h40, 7'h40, 7'h40);
        vecs[10] = mk(31, 63, 63, 0, 1, 1, 7'h30, 7'h79, 7'h02, 7'h30, 7'h02, 7'h30);
        vecs[11] = mk( 9,  7, 48, 0, 1, 1, H0,    7'h10, 7'h40, 7'h78, 7'h19, 7'h00);
        vecs[12] = mk(20, 10, 19, 0, 1, 1, 7'h24, 7'h40, 7'h79, 7'h40, 7'h79, 7'h10);
        vecs[13] = mk( 0,  0,  0, 0, 1, 1, H0,    7'h40, 7'h40, 7'h40, 7'h40, 7'h40);

        // Reset state and release with all-zero inputs.
        @(negedge clk);
        @(negedge clk);
        check("reset_hex", hex_all, ALL_BLANK);
        check("reset_busy", 42'(busy), 42'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        check("pre_conv_hex", hex_all, ALL_BLANK);
        check("pre_conv_busy", 42'(busy), 42'd0);
        sb_q.push_back({H0, {5{7'h40}}});
        bcnt = 0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            if (busy) bcnt++;
            if (e == 7) check("edge7_still_blank", hex_all, ALL_BLANK);
        end
        check("busy_cycles", 42'(bcnt), 42'd7);
        check("busy_after_done", 42'(busy), 42'd0);
        pop_check("reset_release_zero");

        // Vector table.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].md, vecs[i].bl);
            sb_q.push_back(vecs[i].exp);
            if (vecs[i].conv) begin
                wait_done(edges, ok);
                if (!ok) begin
                    check($sformatf("vec%0d_timeout", i), 42'd0, 42'd1);
                    void'(sb_q.pop_front());
                end else begin
                    check($sformatf("vec%0d_latency", i), 42'(edges), 42'd8);
                    pop_check($sformatf("vec%0d", i));
                end
            end else begin
                #2;
                pop_check($sformatf("vec%0d_mask", i));
                @(posedge clk);
                #1;
                check($sformatf("vec%0d_no_conv", i), 42'(busy), 42'd0);
            end
        end

        // Seconds change 10 -> 11 on the third cycle of a running conversion.
        drive(0, 0, 10, 0, 1);
        sb_q.push_back({H0, 7'h40, 7'h40, 7'h40, 7'h79, 7'h40});
        sb_q.push_back({H0, 7'h40, 7'h40, 7'h40, 7'h79, 7'h79});
        repeat (3) @(posedge clk);
        #1;
        segundos = 6'd11;
        wait_done(edges, ok);
        if (ok) pop_check("mid_change_first");
        else begin
            check("mid_change_first_timeout", 42'd0, 42'd1);
            void'(sb_q.pop_front());
        end
        wait_done(e2, ok);
        if (ok) pop_check("mid_change_final");
        else begin
            check("mid_change_final_timeout", 42'd0, 42'd1);
            void'(sb_q.pop_front());
        end
        check("mid_change_within16", 42'(edges + e2 <= 16), 42'd1);
        extra = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (busy) extra++;
        end
        check("no_extra_conv", 42'(extra), 42'd0);

        // One-cycle reset pulse in the middle of SHIFT.
        drive(12, 34, 56, 0, 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_hex", hex_all, ALL_BLANK);
        check("midrst_busy", 42'(busy), 42'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.push_back({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
        wait_done(edges, ok);
        if (ok) begin
            check("midrst_recover_latency", 42'(edges), 42'd8);
            pop_check("midrst_recover");
        end else begin
            check("midrst_timeout", 42'd0, 42'd1);
            void'(sb_q.pop_front());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
